uart_word_tx: RTL
=================

UART_WORD_TX -- requirements
Module: uart_word_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 200, meaning clock cycles per UART bit; legal range 2..65535.
REQ-002 The block SHALL have port clk  input  1  single system clock; all state changes occur on its rising edge.
REQ-003 The block SHALL have port fpga_rst  input  1  synchronous, active-high reset.
REQ-004 The block SHALL have port tx_word  input  32  word to transmit, sampled at acceptance.
REQ-005 The block SHALL have port tx_valid  input  1  request to send tx_word.
REQ-006 The block SHALL have port tx_ready  output  1  high when a new word can be accepted.
REQ-007 The block SHALL have port tx_done  output  1  one-cycle pulse marking the end of a word.
REQ-008 The block SHALL have port tx  output  1  serial line, 8N1 framing, idle high.

Function
REQ-009 The block SHALL accept a word on a rising edge where tx_valid=1 and tx_ready=1, and latch tx_word into an internal shift register.
REQ-010 The block SHALL drive tx_ready=1 only in state IDLE and tx_ready=0 from the cycle after acceptance until the word completes.
REQ-011 The block SHALL ignore tx_valid and tx_word while tx_ready=0; there is no queueing and a later tx_word change does not alter the word in flight.
REQ-012 The block SHALL send 4 bytes per word, least-significant byte first (bits 7:0, 15:8, 23:16, 31:24).
REQ-013 The block SHALL send each byte as start bit (0), data bits LSB first, then stop bit (1), each bit lasting exactly CLKS_PER_BIT cycles.
REQ-014 The block SHALL implement states IDLE -> START -> DATA -> STOP; STOP goes to START if bytes remain, else to IDLE.
REQ-015 The block SHALL insert no idle cycles between bytes of one word: the next start bit follows the last stop-bit cycle immediately.
REQ-016 The tx output SHALL be registered, so if acceptance occurs at edge k, tx=0 during cycles k+1 .. k+CLKS_PER_BIT.
REQ-017 The total word duration SHALL be exactly 40*CLKS_PER_BIT cycles, covering cycles k+1 .. k+40*CLKS_PER_BIT.
REQ-018 The block SHALL assert tx_done for exactly one cycle, in cycle k+40*CLKS_PER_BIT (the final stop-bit cycle).
REQ-019 The block SHALL reassert tx_ready in cycle k+40*CLKS_PER_BIT+1, so back-to-back words have exactly one idle-high cycle between them.
REQ-020 The bit-timing counter SHALL be 16 bits, count 0 .. CLKS_PER_BIT-1, and reload to 0 on each bit boundary with no wrap glitch.
REQ-021 The bit index (0..7) and byte index (0..3) counters SHALL reset to 0 at each new byte and word respectively.
REQ-022 In IDLE, the block SHALL hold tx=1 regardless of tx_word.

Reset
REQ-023 While fpga_rst=1 at a rising edge, the block SHALL enter IDLE and set tx=1, tx_ready=1, tx_done=0, and all counters to 0.
REQ-024 A reset during any transfer SHALL abort it, discard the remaining bits, and drive tx=1 from the cycle after the reset edge, with no tx_done pulse.
REQ-025 If fpga_rst=1 and tx_valid=1 on the same edge, reset SHALL win and no word is accepted.
REQ-026 After reset deasserts, the first word SHALL be accepted no earlier than the first edge where fpga_rst=0.

Verification (CLKS_PER_BIT=4)
REQ-027 Reset check: hold fpga_rst=1 for 5 cycles with tx_valid=0 -> tx=1, tx_ready=1, tx_done=0 throughout and after release.
REQ-028 Single word: tx_word=0x80010007 pulsed valid -> line decodes bytes 07,00,01,80 in order; 160 cycles; tx_done at cycle 160; tx_ready at cycle 161.
REQ-029 Back-to-back: hold tx_valid=1 with words 0x7F000000 then 0x01000040 -> exactly one tx=1 idle cycle between them; decoded bytes 00,00,00,7F,40,00,00,01.
REQ-030 Ignore while busy: change tx_word to 0xFFFFFFFF mid-transfer of 0x00000000 -> all 32 data bits sent as 0; no extra word sent after.
REQ-031 Abort: assert fpga_rst during the data bits of byte 2 -> tx=1 on the next cycle, no tx_done; a subsequent word 0x12345678 transmits correctly as 78,56,34,12.
REQ-032 Timing: measure every bit width in REQ-028 -> every bit is exactly 4 cycles; start-bit falling edge occurs one cycle after acceptance.

Source files
------------

// File: rtl/uart_word_tx.sv
// UART word transmitter: serialises a 32-bit word as four 8N1 bytes, LSB byte first.
// The next byte's start bit follows its predecessor's stop bit with no idle gap.
module uart_word_tx #(
  parameter int unsigned CLKS_PER_BIT = 200
) (
  input  logic        clk,
  input  logic        fpga_rst,
  input  logic [31:0] tx_word,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        tx_done,
  output logic        tx
);

  localparam int unsigned CNT_W    = 16;
  localparam int unsigned WORD_W   = 32;
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] DONE_AT  = CNT_W'(CLKS_PER_BIT - 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [2:0]         bit_idx;
  logic [1:0]         byte_idx;
  logic [WORD_W-1:0]  shreg;

  logic bit_end_c;
  assign bit_end_c = (bit_cnt == BIT_LAST);

  always_ff @(posedge clk) begin
    if (fpga_rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: begin
          tx      <= 1'b1;
          bit_cnt <= '0;
          // tx_ready is always high here, so tx_valid alone marks acceptance
          if (tx_valid) begin
            shreg    <= tx_word;
            state    <= START;
            tx       <= 1'b0;
            tx_ready <= 1'b0;
            bit_idx  <= '0;
            byte_idx <= '0;
          end
        end

        START: begin
          if (bit_end_c) begin
            bit_cnt <= '0;
            bit_idx <= '0;
            state   <= DATA;
            tx      <= shreg[0];
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (bit_end_c) begin
            bit_cnt <= '0;
            // Shifting once per data bit leaves the next byte in bits 7:0 after eight bits
            shreg   <= {1'b0, shreg[WORD_W-1:1]};
            if (bit_idx == 3'd7) begin
              state <= STOP;
              tx    <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[1];
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        STOP: begin
          // Registered one cycle early so the pulse lands on the final stop-bit cycle
          if (byte_idx == 2'd3 && bit_cnt == DONE_AT) begin
            tx_done <= 1'b1;
          end
          if (bit_end_c) begin
            bit_cnt <= '0;
            if (byte_idx == 2'd3) begin
              state    <= IDLE;
              tx_ready <= 1'b1;
              byte_idx <= '0;
            end else begin
              byte_idx <= byte_idx + 2'd1;
              bit_idx  <= '0;
              state    <= START;
              tx       <= 1'b0;
            end
          end else begin
            bit_cnt <= bit_cnt + CNT_W'(1);
          end
        end

        default: begin
          state    <= IDLE;
          tx       <= 1'b1;
          tx_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
